multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multicycle RV32I datapath. It decodes the instruction register (opcode, funct3, funct7[5]), steps a Moore state machine through fetch/decode/execute/memory/writeback, and drives every datapath select and write enable. It is the producer side of the ALU interface: it issues `alu_control` codes and consumes the ALU `zero` flag to resolve branches.

## Interface
- No parameters. State and code widths are fixed.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous reset, active-low.
- `opcode` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `alu_control` out 4:
  - 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0100 SLT.
  - 1111 marks an unsupported funct3.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 rs1 register A.
- `alu_src_b` out 2: 00 rs2 register B, 01 ImmExt, 10 constant 4.
- `result_src` out 2: 00 ALUOut, 01 Data register, 10 ALUResult.
- `imm_src` out 2: 00 I, 01 S, 10 B, 11 J.
- `adr_src` out 1: 0 PC, 1 Result.
- `ir_write` out 1: instruction register enable.
- `pc_write` out 1: PC enable.
- `reg_write` out 1: register file write enable.
- `mem_write` out 1: data memory write enable.
- `illegal` out 1: one-cycle pulse in DECODE for an unsupported opcode or funct3.

## Operation
- **State register:** updates on rising `clk`. When `rst_n`=0 at the edge, next state is FETCH.
- **Decode policy:** outputs are decoded combinationally from state.
  - `alu_control` in EXECUTER/EXECUTEI also depends on funct3/funct7b5.
  - `pc_write` in BEQ also depends on `zero`.
- **Defaults:** every enable = 0, selects = 00, `alu_control` = ADD, unless listed per state.
- **FETCH:** `adr_src`=0, `ir_write`=1, A=00, B=10, ADD, `result_src`=10, `pc_write`=1 → DECODE.
- **DECODE:** A=01, B=01, ADD (branch/jump target into ALUOut). Next state by opcode:
  - lw 0000011 / sw 0100011 → MEMADR
  - R 0110011 → EXECUTER
  - I 0010011 → EXECUTEI
  - beq 1100011 → BEQ
  - jal 1101111 → JAL
  - any other → FETCH with `illegal`=1
- **MEMADR:** A=10, B=01, ADD → MEMREAD (lw) or MEMWRITE (sw).
- **MEMREAD:** `result_src`=00, `adr_src`=1 → MEMWB.
- **MEMWB:** `result_src`=01, `reg_write`=1 → FETCH.
- **MEMWRITE:** `result_src`=00, `adr_src`=1, `mem_write`=1 → FETCH.
- **EXECUTER:** A=10, B=00, funct decode → ALUWB.
- **EXECUTEI:** A=10, B=01, funct decode → ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1 → FETCH.
- **BEQ:** A=10, B=00, SUB, `result_src`=00, `pc_write`=`zero` → FETCH.
- **JAL:** A=01, B=10, ADD, `result_src`=00, `pc_write`=1 → ALUWB (writes PC+4 to rd).
- **Funct decode** (funct3):
  - 000: ADD, or SUB when R-type and funct7b5=1. I-type with funct7b5=1 is ADD.
  - 010: SLT. 100: XOR. 110: OR. 111: AND.
  - 001/011/101: `alu_control`=1111. `illegal` pulses in DECODE for R/I opcodes with these funct3. The FSM still proceeds through EXECUTE/ALUWB (no trap).
- **`imm_src`:** combinational from opcode in all states: sw→01, beq→10, jal→11, else 00.

## Timing
- **Reset outputs:**
  - While `rst_n`=0, `pc_write`, `ir_write`, `reg_write`, `mem_write` and `illegal` are forced 0 combinationally.
  - Selects and `alu_control` show FETCH values.
  - The first fetch occurs in the first cycle with `rst_n`=1 after a reset edge.
- **Reset mid-instruction:** `rst_n`=0 in any state aborts at the next edge. No write enable asserts in the reset cycle.
- **Latency (cycles, FETCH to next FETCH):**
  - lw 5; sw 4; R-type 4; I-type 4; beq 3; jal 4; illegal opcode 2.
- **`zero`:** sampled combinationally in BEQ only. It is ignored in every other state.
- **`ir_write`:** asserts only in FETCH. Opcode/funct inputs are stable from DECODE until the next FETCH.
- **Write enables:** each asserts for exactly one cycle per instruction, except `pc_write` (FETCH plus BEQ-taken or JAL).

## Test plan
- **Reset:** hold `rst_n`=0 3 cycles from arbitrary state → all enables 0; release → FETCH outputs (`ir_write`=1, `pc_write`=1, B=10, ADD), then DECODE.
- **lw:** opcode 0000011 → 5-cycle sequence; `reg_write`=1 only in cycle 5 with `result_src`=01; `mem_write` never asserts.
- **sw/R-type:**
  - sw → `mem_write`=1 in cycle 4, `adr_src`=1, `imm_src`=01.
  - R-type funct3=000, funct7b5=1 → SUB (0110) in EXECUTER.
  - funct3=111 → AND (0000).
  - I-type funct3=000, funct7b5=1 → ADD (0010).
- **beq:** with `zero`=1, `pc_write`=1 in cycle 3; with `zero`=0, `pc_write`=0; 3-cycle latency; `alu_control`=0110.
- **jal, illegal opcode, unsupported funct3:**
  - jal → `pc_write` in cycle 3, `reg_write` in cycle 4.
  - opcode 1111111 → `illegal`=1 in DECODE, back to FETCH in 2 cycles, no writes.
  - R-type funct3=001 → `illegal` pulse, `alu_control`=1111 in EXECUTER.
- **Reset in MEMWRITE:** `rst_n`=0 during MEMWRITE → `mem_write`=0 that cycle; next state FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencing controller: Moore FSM plus instruction decode.
// Drives datapath selects/enables and issues ALU codes; resolves beq from zero.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [3:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] R_ALUOUT = 2'b00, R_DATA = 2'b01, R_ALURES = 2'b10;

  state_t state, state_nxt, cur;
  logic [3:0] funct_alu;
  logic       funct_bad;
  logic       op_bad;
  logic       op_ri;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Held in reset, outputs present the FETCH selects regardless of stored state.
  assign cur   = rst_n ? state : FETCH;
  assign op_ri = (opcode == OP_R) || (opcode == OP_I);

  always_comb begin
    op_bad = 1'b1;
    case (opcode)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_bad = 1'b0;
      default:                                  op_bad = 1'b1;
    endcase
  end

  // funct7b5 selects SUB only for R-type; I-type addi ignores it.
  always_comb begin
    funct_alu = ALU_ADD;
    funct_bad = 1'b0;
    case (funct3)
      3'b000:  funct_alu = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b100:  funct_alu = ALU_XOR;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: begin
        funct_alu = ALU_BAD;
        funct_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_nxt   = FETCH;
    alu_control = ALU_ADD;
    alu_src_a   = A_PC;
    alu_src_b   = B_RS2;
    result_src  = R_ALUOUT;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal     = 1'b0;
    case (cur)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        result_src = R_ALURES;
        pc_write   = 1'b1;
        state_nxt  = DECODE;
      end
      DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        illegal   = op_bad || (op_ri && funct_bad);
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECUTER;
          OP_I:         state_nxt = EXECUTEI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        result_src = R_ALUOUT;
        adr_src    = 1'b1;
        state_nxt  = MEMWB;
      end
      MEMWB: begin
        result_src = R_DATA;
        reg_write  = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        result_src = R_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_nxt  = FETCH;
      end
      EXECUTER: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_RS2;
        alu_control = funct_alu;
        state_nxt   = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_IMM;
        alu_control = funct_alu;
        state_nxt   = ALUWB;
      end
      ALUWB: begin
        result_src = R_ALUOUT;
        reg_write  = 1'b1;
        state_nxt  = FETCH;
      end
      BEQ: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_RS2;
        alu_control = ALU_SUB;
        result_src  = R_ALUOUT;
        pc_write    = zero;
        state_nxt   = FETCH;
      end
      JAL: begin
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        result_src = R_ALUOUT;
        pc_write   = 1'b1;
        state_nxt  = ALUWB;
      end
      default: state_nxt = FETCH;
    endcase
    if (!rst_n) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset corner cases,
// and random instruction streams checked against a per-instruction cycle model.
module tb_multicycle_control;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic [3:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .alu_control(alu_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] a, b, rs, imm;
    logic       adr, irw, pcw, rw, mw, ill;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    int         lat, cyc;
    outs_t      exp;
  } vec_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000;
  localparam logic [3:0] OR_ = 4'b0001, XOR_ = 4'b0011, SLT = 4'b0100, BAD = 4'b1111;

  outs_t got;
  assign got = {alu_control, alu_src_a, alu_src_b, result_src, imm_src,
                adr_src, ir_write, pc_write, reg_write, mem_write, illegal};

  int    errors = 0, checks = 0;
  vec_t  vq[$];
  outs_t seq[8];
  int    seq_n;
  logic [3:0] alu_tab [8];
  logic [6:0] legal_ops [6];

  function automatic outs_t mk(logic [3:0] alu, logic [1:0] a, logic [1:0] b,
                               logic [1:0] rs, logic [1:0] imm, logic adr, logic irw,
                               logic pcw, logic rw, logic mw, logic ill);
    outs_t o;
    o = {alu, a, b, rs, imm, adr, irw, pcw, rw, mw, ill};
    return o;
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] op);
    if (op == SW) return 2'd1;
    if (op == BQ) return 2'd2;
    if (op == JL) return 2'd3;
    return 2'd0;
  endfunction

  function automatic outs_t reset_out(logic [6:0] op);
    return mk(ADD, 2'd0, 2'd2, 2'd2, imm_of(op), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(string nm, logic [31:0] g, logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  // Expected per-cycle outputs of one instruction, FETCH first.
  task automatic build(logic [6:0] op, logic [2:0] f3, logic f7, logic zb);
    logic [1:0] im;
    logic       legal, badf;
    logic [3:0] av;
    outs_t      wb;
    im    = imm_of(op);
    legal = (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BQ) || (op == JL);
    badf  = (alu_tab[f3] == BAD);
    av    = (f3 == 3'd0 && op == RT && f7) ? SUB : alu_tab[f3];
    wb    = mk(ADD, 2'd0, 2'd0, 2'd0, im, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    seq[0] = mk(ADD, 2'd0, 2'd2, 2'd2, im, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    seq[1] = mk(ADD, 2'd1, 2'd1, 2'd0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                !legal || ((op == RT || op == IT) && badf));
    seq_n = 2;
    if (op == LW || op == SW)
      seq[2] = mk(ADD, 2'd2, 2'd1, 2'd0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (op == LW) begin
      seq[3] = mk(ADD, 2'd0, 2'd0, 2'd0, im, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      seq[4] = mk(ADD, 2'd0, 2'd0, 2'd1, im, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      seq_n = 5;
    end else if (op == SW) begin
      seq[3] = mk(ADD, 2'd0, 2'd0, 2'd0, im, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      seq_n = 4;
    end else if (op == RT || op == IT) begin
      seq[2] = mk(av, 2'd2, (op == IT) ? 2'd1 : 2'd0, 2'd0, im, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      seq[3] = wb;
      seq_n = 4;
    end else if (op == BQ) begin
      seq[2] = mk(SUB, 2'd2, 2'd0, 2'd0, im, 1'b0, 1'b0, zb, 1'b0, 1'b0, 1'b0);
      seq_n = 3;
    end else if (op == JL) begin
      seq[2] = mk(ADD, 2'd1, 2'd2, 2'd0, im, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      seq[3] = wb;
      seq_n = 4;
    end
  endtask

  task automatic add(string nm, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                     int lat, int cyc, outs_t e);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
    v.lat = lat; v.cyc = cyc; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    alu_tab   = '{ADD, BAD, SLT, BAD, XOR_, BAD, OR_, AND_};
    legal_ops = '{LW, SW, RT, IT, BQ, JL};

    add("lw_wb",    LW, 3'd2, 1'b0, 1'b0, 5, 5, mk(ADD, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    add("lw_read",  LW, 3'd2, 1'b0, 1'b1, 5, 4, mk(ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add("sw_write", SW, 3'd2, 1'b0, 1'b1, 4, 4, mk(ADD, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    add("sw_adr",   SW, 3'd2, 1'b1, 1'b0, 4, 3, mk(ADD, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    add("r_sub",    RT, 3'd0, 1'b1, 1'b0, 4, 3, mk(SUB, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("r_and",    RT, 3'd7, 1'b0, 1'b1, 4, 3, mk(AND_, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("i_add_f7", IT, 3'd0, 1'b1, 1'b0, 4, 3, mk(ADD, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("i_slt",    IT, 3'd2, 1'b0, 1'b0, 4, 3, mk(SLT, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("r_xor",    RT, 3'd4, 1'b0, 1'b0, 4, 3, mk(XOR_, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("i_or",     IT, 3'd6, 1'b1, 1'b0, 4, 3, mk(OR_, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("beq_tkn",  BQ, 3'd0, 1'b0, 1'b1, 3, 3, mk(SUB, 2, 0, 0, 2, 0, 0, 1, 0, 0, 0));
    add("beq_nt",   BQ, 3'd0, 1'b0, 1'b0, 3, 3, mk(SUB, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    add("jal_pc",   JL, 3'd0, 1'b0, 1'b0, 4, 3, mk(ADD, 1, 2, 0, 3, 0, 0, 1, 0, 0, 0));
    add("jal_wb",   JL, 3'd0, 1'b0, 1'b1, 4, 4, mk(ADD, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0));
    add("ill_op",   7'h7f, 3'd0, 1'b0, 1'b0, 2, 2, mk(ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add("f3_ill",   RT, 3'd1, 1'b0, 1'b0, 4, 2, mk(ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add("f3_alu",   RT, 3'd1, 1'b0, 1'b0, 4, 3, mk(BAD, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("f3_wb",    IT, 3'd5, 1'b0, 1'b0, 4, 4, mk(ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // Reset held three cycles from power-up state.
    rst_n = 1'b0; opcode = BQ; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_hold", 32'(got), 32'(reset_out(opcode)));
      tick();
    end
    rst_n = 1'b1;

    // Directed table; a FETCH at cycle 1 also proves the previous latency.
    foreach (vq[i]) begin
      opcode = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7; zero = vq[i].z;
      for (int c = 1; c <= vq[i].lat; c++) begin
        @(negedge clk);
        if (c == 1) chk({vq[i].name, "_fetch"}, 32'(ir_write), 32'd1);
        if (c == vq[i].cyc) chk(vq[i].name, 32'(got), 32'(vq[i].exp));
        tick();
      end
    end

    // Reset asserted in MEMWRITE: no store, then straight back to FETCH.
    opcode = SW; funct3 = 3'd2; funct7b5 = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_memwrite", 32'(got), 32'(reset_out(SW)));
    tick();
    rst_n = 1'b1;
    opcode = JL;
    build(JL, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_refetch", 32'(got), 32'(seq[0]));
    tick();
    @(negedge clk);
    chk("rst_decode", 32'(got), 32'(seq[1]));
    tick();
    for (int c = 2; c < seq_n; c++) tick();

    // Random stream, zero toggled every cycle, occasional mid-instruction reset.
    for (int k = 0; k < 300; k++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [7:0] zs;
      int         rst_at;
      int         sel;
      sel = $urandom_range(0, 7);
      op  = (sel < 6) ? legal_ops[sel] : 7'($urandom);
      f3  = 3'($urandom);
      f7  = 1'($urandom);
      zs  = 8'($urandom);
      build(op, f3, f7, zs[2]);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, seq_n - 1) : -1;
      for (int c = 0; c < seq_n; c++) begin
        opcode = op; funct3 = f3; funct7b5 = f7; zero = zs[c];
        rst_n  = (c == rst_at) ? 1'b0 : 1'b1;
        @(negedge clk);
        if (c == rst_at) chk("rand_reset", 32'(got), 32'(reset_out(op)));
        else             chk("rand_step", 32'(got), 32'(seq[c]));
        tick();
        if (c == rst_at) break;
      end
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
